// File: rtl/dmem_bram_if.sv
// Request/response bus between a load/store unit (master) and the dmem_bram data memory (slave).
interface dmem_bram_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_func3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bram.sv
// dmem_bram: single-port block-RAM data memory with byte/half/word loads and stores.
// Macro DMEM_MISALIGN_SPLIT_EN: word-crossing accesses run as two beats instead of erroring.
module dmem_bram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_bram_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned WA_W  = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, RESP, SPLIT} state_t;

    // Zero-initialised at configuration; reset never touches the contents.
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    state_t           state_q;
    logic             ready_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic             rsp_load_q;
    logic             rsp_split_q;
    logic [1:0]       rsp_off_q;
    logic [2:0]       rsp_func3_q;
    logic [IDX_W-1:0] idx1_q;
    logic             split_we_q;
    logic [3:0]       strb_hi_q;
    logic [31:0]      wd_hi_q;
    logic [31:0]      mem_rd_q;
    logic [31:0]      lo_hold_q;

    logic [WA_W-1:0]  waddr_c;
    logic [IDX_W-1:0] idx0_c;
    logic [1:0]       off_c;
    logic [3:0]       bmask_c;
    logic             acc_c;
    logic             func_err_c;
    logic             oob_c;
    logic             err_c;
    logic             split_c;
    logic [63:0]      wd64_c;
    logic [7:0]       strb8_c;
    logic [IDX_W-1:0] mem_idx_c;
    logic [3:0]       mem_we_c;
    logic [31:0]      mem_wd_c;
    logic [31:0]      shifted_c;
    logic [31:0]      ext_c;
`ifdef DMEM_MISALIGN_SPLIT_EN
    logic             cross_c;
`endif

    // Request decode: legality, lane strobes and lane-shifted store data over a two-word window.
    always_comb begin
        waddr_c = bus.req_addr[ADDR_W-1:2];
        idx0_c  = waddr_c[IDX_W-1:0];
        off_c   = bus.req_addr[1:0];
        acc_c   = rst_n && bus.req_valid && ready_q;
        case (bus.req_func3[1:0])
            2'd0:    bmask_c = 4'b0001;
            2'd1:    bmask_c = 4'b0011;
            default: bmask_c = 4'b1111;
        endcase
        if (bus.req_we) func_err_c = (bus.req_func3 > 3'd2);
        else            func_err_c = (bus.req_func3 == 3'd3) || (bus.req_func3 >= 3'd6);
        // Upper address bits are range-checked, never wrapped.
        oob_c = (waddr_c >= WA_W'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_SPLIT_EN
        cross_c = ((bus.req_func3[1:0] == 2'd1) && (off_c == 2'd3)) ||
                  ((bus.req_func3[1:0] == 2'd2) && (off_c != 2'd0));
        err_c   = func_err_c || oob_c || (cross_c && (waddr_c == WA_W'(DEPTH_WORDS - 1)));
        split_c = cross_c && !err_c;
`else
        err_c   = func_err_c || oob_c ||
                  ((bus.req_func3[1:0] == 2'd1) && off_c[0]) ||
                  ((bus.req_func3[1:0] == 2'd2) && (off_c != 2'd0));
        split_c = 1'b0;
`endif
        wd64_c  = 64'(bus.req_wdata) << {off_c, 3'b000};
        strb8_c = 8'(bmask_c) << off_c;
    end

    // Single RAM port: second beat in SPLIT, otherwise the accepted request.
    always_comb begin
        mem_idx_c = idx0_c;
        mem_wd_c  = wd64_c[31:0];
        mem_we_c  = 4'b0000;
        if (state_q == SPLIT) begin
            mem_idx_c = idx1_q;
            mem_wd_c  = wd_hi_q;
            if (rst_n && split_we_q) mem_we_c = strb_hi_q;
        end else if (acc_c && bus.req_we && !err_c) begin
            mem_we_c = strb8_c[3:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we_c[i]) mem[mem_idx_c][8*i +: 8] <= mem_wd_c[8*i +: 8];
        end
        mem_rd_q <= mem[mem_idx_c];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_split_q <= 1'b0;
            rsp_off_q   <= '0;
            rsp_func3_q <= '0;
            idx1_q      <= '0;
            split_we_q  <= 1'b0;
            strb_hi_q   <= '0;
            wd_hi_q     <= '0;
            lo_hold_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ready_q     <= 1'b1;
            case (state_q)
                IDLE, RESP: begin
                    if (acc_c) begin
                        rsp_off_q   <= off_c;
                        rsp_func3_q <= bus.req_func3;
                        rsp_load_q  <= !bus.req_we && !err_c;
                        rsp_split_q <= split_c;
                        if (split_c) begin
                            state_q    <= SPLIT;
                            ready_q    <= 1'b0;
                            idx1_q     <= idx0_c + IDX_W'(1);
                            split_we_q <= bus.req_we;
                            strb_hi_q  <= strb8_c[7:4];
                            wd_hi_q    <= wd64_c[63:32];
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= err_c;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SPLIT: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    lo_hold_q   <= mem_rd_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Load alignment and extension sit behind the RAM output register to keep one-cycle latency.
    always_comb begin
        shifted_c = 32'({mem_rd_q, (rsp_split_q ? lo_hold_q : mem_rd_q)} >> {rsp_off_q, 3'b000});
        case (rsp_func3_q)
            3'd0:    ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'd1:    ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'd4:    ext_c = {24'd0, shifted_c[7:0]};
            3'd5:    ext_c = {16'd0, shifted_c[15:0]};
            default: ext_c = shifted_c;
        endcase
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = (rsp_valid_q && rsp_load_q) ? ext_c : 32'd0;
endmodule

// File: tb/tb_dmem_bram.sv
// Directed bench for dmem_bram: expected responses are queued at issue and matched as they return.
module tb_dmem_bram;
    localparam logic [2:0] F_B  = 3'd0;
    localparam logic [2:0] F_H  = 3'd1;
    localparam logic [2:0] F_W  = 3'd2;
    localparam logic [2:0] F_BU = 3'd4;
    localparam logic [2:0] F_HU = 3'd5;

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t  sb[$];
    string tagq[$];

    dmem_bram_if #(.ADDR_W(32)) bus ();

    dmem_bram #(.DEPTH_WORDS(1024), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t  e;
        string t;
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                t = tagq.pop_front();
                chk({t, "_err"}, 32'(bus.rsp_err), 32'(e.err));
                chk({t, "_rdata"}, bus.rsp_rdata, e.rd);
                chk({t, "_cycle"}, 32'(cyc), e.cyc);
            end
        end
    end

    task automatic issue(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd, input int lat);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_func3 = f3;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        while (bus.req_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) begin
            chk({tag, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
        end else begin
            e.err = e_err;
            e.rd  = e_rd;
            e.cyc = 32'(cyc + lat);
            sb.push_back(e);
            tagq.push_back(tag);
            @(posedge clk);
        end
    endtask

    task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic e_err, input int lat);
        issue(tag, 1'b1, f3, a, wd, e_err, 32'd0, lat);
    endtask

    task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] e_rd,
                      input logic e_err, input int lat);
        issue(tag, 1'b0, f3, a, 32'd0, e_err, e_rd, lat);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_func3 = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Word store then load, back to back, plus an untouched (zero) word.
        st("sw_10", F_W, 32'h10, 32'hDEADBEEF, 1'b0, 1);
        ld("lw_10", F_W, 32'h10, 32'hDEADBEEF, 1'b0, 1);
        ld("lw_40_zero", F_W, 32'h40, 32'h0, 1'b0, 1);

        // Sub-word stores touch only their lanes; loads sign/zero extend.
        st("sw_20", F_W, 32'h20, 32'hA1B2C3D4, 1'b0, 1);
        st("sb_21", F_B, 32'h21, 32'h12345680, 1'b0, 1);
        ld("lb_21", F_B, 32'h21, 32'hFFFFFF80, 1'b0, 1);
        ld("lbu_21", F_BU, 32'h21, 32'h00000080, 1'b0, 1);
        ld("lw_20_a", F_W, 32'h20, 32'hA1B280D4, 1'b0, 1);
        ld("lh_22", F_H, 32'h22, 32'hFFFFA1B2, 1'b0, 1);
        ld("lhu_22", F_HU, 32'h22, 32'h0000A1B2, 1'b0, 1);
        st("sh_22", F_H, 32'h22, 32'hABCD7F01, 1'b0, 1);
        ld("lw_20_b", F_W, 32'h20, 32'h7F0180D4, 1'b0, 1);
        ld("lh_22_pos", F_H, 32'h22, 32'h00007F01, 1'b0, 1);
        ld("lb_20", F_B, 32'h20, 32'hFFFFFFD4, 1'b0, 1);
        ld("lbu_23", F_BU, 32'h23, 32'h0000007F, 1'b0, 1);
        st("sw_1c", F_W, 32'h1C, 32'h55667788, 1'b0, 1);

`ifdef DMEM_MISALIGN_SPLIT_EN
        st("sw_1e_split", F_W, 32'h1E, 32'h11223344, 1'b0, 2);
        @(negedge clk);
        chk("split_st_ready", 32'(bus.req_ready), 32'd0);
        ld("lw_1e_split", F_W, 32'h1E, 32'h11223344, 1'b0, 2);
        @(negedge clk);
        chk("split_ld_ready", 32'(bus.req_ready), 32'd0);
        ld("lw_1c_after", F_W, 32'h1C, 32'h33447788, 1'b0, 1);
        ld("lw_20_after", F_W, 32'h20, 32'h7F011122, 1'b0, 1);
        ld("lh_1f_split", F_H, 32'h1F, 32'h00002233, 1'b0, 2);
        ld("lh_21_inword", F_H, 32'h21, 32'h00000111, 1'b0, 1);
`else
        st("sw_1e_mis", F_W, 32'h1E, 32'h11223344, 1'b1, 1);
        ld("lw_1c_kept", F_W, 32'h1C, 32'h55667788, 1'b0, 1);
        ld("lw_20_kept", F_W, 32'h20, 32'h7F0180D4, 1'b0, 1);
        ld("lh_21_mis", F_H, 32'h21, 32'h0, 1'b1, 1);
        ld("lw_22_mis", F_W, 32'h22, 32'h0, 1'b1, 1);
`endif

        // Range and func3 errors; the last word is still usable.
        ld("lw_oob", F_W, 32'h1000, 32'h0, 1'b1, 1);
        st("sbu_err", F_BU, 32'h10, 32'h000000FF, 1'b1, 1);
        st("s_f7_err", 3'd7, 32'h10, 32'h00000000, 1'b1, 1);
        ld("l_f3_err", 3'd3, 32'h10, 32'h0, 1'b1, 1);
        ld("lw_10_kept", F_W, 32'h10, 32'hDEADBEEF, 1'b0, 1);
        ld("lw_hi_bits", F_W, 32'h80000010, 32'h0, 1'b1, 1);
        st("sw_last", F_W, 32'hFFC, 32'hCAFEF00D, 1'b0, 1);
        ld("lw_last", F_W, 32'hFFC, 32'hCAFEF00D, 1'b0, 1);
        ld("lw_past_end", F_W, 32'hFFE, 32'h0, 1'b1, 1);
        ld("lbu_fff", F_BU, 32'hFFF, 32'h000000CA, 1'b0, 1);

        // Reset keeps memory contents.
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_release_ready", 32'(bus.req_ready), 32'd1);
        ld("lw_10_after_rst", F_W, 32'h10, 32'hDEADBEEF, 1'b0, 1);

`ifdef DMEM_MISALIGN_SPLIT_EN
        // Reset in SPLIT drops the second beat but keeps the first.
        @(negedge clk);
        chk("split_rst_ready_pre", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_func3 = F_W;
        bus.req_addr  = 32'h31;
        bus.req_wdata = 32'h99887766;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("split_rst_in_split_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("split_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("split_rst_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("split_rst_release_ready", 32'(bus.req_ready), 32'd1);
        ld("lw_30_beat0", F_W, 32'h30, 32'h88776600, 1'b0, 1);
        ld("lw_34_beat1", F_W, 32'h34, 32'h00000000, 1'b0, 1);
`endif

        idle();
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_bram.md
DMEM_BRAM -- requirements
Module: dmem_bram

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit memory words (power of two, minimum 16).
REQ-002 Parameter ADDR_W, default 32, SHALL set the width of the byte address input.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on rising clk.
REQ-005 Port req_valid  input  1  SHALL mark a valid load/store request.
REQ-006 Port req_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-007 Port req_we  input  1  SHALL select the operation: 1 = store, 0 = load.
REQ-008 Port req_func3  input  3  SHALL give the access size: 0 = byte, 1 = half, 2 = word, 4 = unsigned byte, 5 = unsigned half.
REQ-009 Port req_addr  input  ADDR_W  SHALL carry the byte address.
REQ-010 Port req_wdata  input  32  SHALL carry store data, LSB-aligned.
REQ-011 Port rsp_valid  output  1  SHALL pulse for one cycle per accepted request.
REQ-012 Port rsp_rdata  output  32  SHALL carry extended load data, and 0 for stores and errors.
REQ-013 Port rsp_err  output  1  SHALL flag an illegal request; it is qualified by rsp_valid.

Function
REQ-014 A request SHALL be accepted when req_valid and req_ready are both 1; requests are handled in order.
REQ-015 Storage SHALL be DEPTH_WORDS x 32-bit, block-RAM style, with per-byte write strobes and a synchronous read; it SHALL be zero-initialised at configuration.
REQ-016 FSM states: IDLE, RESP, SPLIT. IDLE -> RESP on an aligned or error accept; RESP -> RESP on another accept, else -> IDLE; IDLE/RESP -> SPLIT on a misaligned accept (macro defined only); SPLIT -> RESP unconditionally.
REQ-017 req_ready SHALL be 1 in IDLE and RESP, and 0 in SPLIT and during reset.
REQ-018 For an aligned access, rsp_valid SHALL assert exactly 1 cycle after accept; back-to-back accepts SHALL give 1 response per cycle.
REQ-019 Load data SHALL be taken from byte lanes addr[1:0] upward, with sign extension for func3 0/1 and zero extension for 4/5.
REQ-020 Byte and halfword stores SHALL modify only the addressed bytes; all other bytes keep their value.
REQ-021 A load issued in the cycle after a store to the same word SHALL return the newly stored data (read-after-write, no stale value).
REQ-022 Error cases SHALL be: word index >= DEPTH_WORDS (either beat); a store with func3 4, 5, 3, 6 or 7; a load with func3 3, 6 or 7.
REQ-023 On any error the block SHALL perform no memory write and respond with rsp_err=1, rsp_rdata=0, using aligned latency.
REQ-024 Address bits above log2(DEPTH_WORDS)+2 SHALL only be checked for out-of-range, never wrapped.

Reset
REQ-025 While rst_n=0: state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0.
REQ-026 Reset SHALL NOT clear memory contents.
REQ-027 Reset during SPLIT SHALL abandon the second beat with no response; a first-beat write already committed stays written.

Configuration
REQ-028 Macro DMEM_MISALIGN_SPLIT_EN defined: a misaligned half/word access (one that crosses a word boundary) SHALL execute as two word beats (word N lanes, then word N+1 lanes), with rsp_valid 2 cycles after accept and rsp_err=0.
REQ-029 Macro undefined: an access is misaligned if half has addr[0]=1 or word has addr[1:0]!=0; it SHALL be an error per REQ-023, and SPLIT is unreachable.

Verification
REQ-030 Store word 0xDEADBEEF to 0x10, then load word from 0x10 -> rsp_rdata=0xDEADBEEF, 1-cycle latency each, back-to-back with no bubble.
REQ-031 Store byte 0x80 to 0x21, then load byte and unsigned byte from 0x21 -> 0xFFFFFF80 and 0x00000080; the other bytes of word 0x20 are unchanged.
REQ-032 With the macro defined, store word 0x11223344 to 0x1E, then load word from 0x1E -> 0x11223344, rsp at accept+2, req_ready=0 for one cycle in each access.
REQ-033 With the macro undefined, the same store -> rsp_err=1, and words 0x1C and 0x20 are unchanged.
REQ-034 Load from byte address 4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0; store with func3=4 -> rsp_err=1 and no write.
REQ-035 Assert rst_n=0 in the SPLIT cycle of a misaligned store -> no rsp_valid, word N updated, word N+1 unchanged, req_ready=1 the cycle after release.
